// File: rtl/rca_nibble_seq_if.sv
// Request/response handshake bundle for the nibble-serial add/sub controller.
// The requester holds the master side; the controller holds the slave side.
interface rca_nibble_seq_if #(
    parameter int WIDTH = 16
);
    logic             start_valid;
    logic             start_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             overflow;

    modport master (
        output start_valid, a, b, sub, res_ready,
        input  start_ready, res_valid, result, carry, overflow
    );

    modport slave (
        input  start_valid, a, b, sub, res_ready,
        output start_ready, res_valid, result, carry, overflow
    );
endinterface

// File: rtl/rca_nibble_seq.sv
// WIDTH-bit add/subtract built by reusing an external 4-bit add/sub slice,
// one nibble per clock LSB first, with valid/ready request and result handshakes.
module rca_nibble_seq #(
    parameter int WIDTH = 16
) (
    input  logic                clk,
    input  logic                rst,
    rca_nibble_seq_if.slave     io,
    output logic                busy,
    output logic [3:0]          add_x,
    output logic [3:0]          add_y,
    output logic                add_sel,
    input  logic [3:0]          add_s,
    input  logic                add_cout
);
    localparam int NIB = WIDTH / 4;
    localparam int KW  = $clog2(NIB);
    localparam logic [KW-1:0] K_LAST = KW'(NIB - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] result_r;
    logic [KW-1:0]    k_r;
    logic             c_r;
    logic             carry_r;
    logic             overflow_r;
    logic             res_valid_r;
    logic             start_ready_r;
    logic             busy_r;

    logic [KW+1:0]    base_s;
    logic [3:0]       a_nib_s;
    logic [3:0]       b_nib_s;
    logic             ovf_s;

    // Signed overflow: operands of equal sign produced a sum of the other sign.
    function automatic logic ovf_calc(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

    // Select the active nibble and condition the slice so it always adds.
    always_comb begin
        base_s  = {k_r, 2'b00};
        a_nib_s = a_r[base_s +: 4];
        b_nib_s = b_r[base_s +: 4];
        ovf_s   = ovf_calc(a_r[WIDTH-1], b_r[WIDTH-1], add_s[3]);
        add_x   = 4'd0;
        add_y   = 4'd0;
        add_sel = 1'b0;
        if (state_r == RUN) begin
            // The slice inverts y when sel=1, so pre-inverting yields x + b + c.
            add_x   = a_nib_s;
            add_y   = b_nib_s ^ {4{c_r}};
            add_sel = c_r;
        end else begin
            add_x   = 4'd0;
            add_y   = 4'd0;
            add_sel = 1'b0;
        end
    end

    // Controller FSM with all handshake and result outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= IDLE;
            a_r           <= {WIDTH{1'b0}};
            b_r           <= {WIDTH{1'b0}};
            result_r      <= {WIDTH{1'b0}};
            k_r           <= {KW{1'b0}};
            c_r           <= 1'b0;
            carry_r       <= 1'b0;
            overflow_r    <= 1'b0;
            res_valid_r   <= 1'b0;
            start_ready_r <= 1'b1;
            busy_r        <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (io.start_valid && start_ready_r) begin
                        a_r           <= io.a;
                        b_r           <= io.sub ? ~io.b : io.b;
                        c_r           <= io.sub;
                        k_r           <= {KW{1'b0}};
                        start_ready_r <= 1'b0;
                        busy_r        <= 1'b1;
                        state_r       <= RUN;
                    end else begin
                        state_r       <= IDLE;
                    end
                end
                RUN: begin
                    result_r[base_s +: 4] <= add_s;
                    c_r                   <= add_cout;
                    if (k_r == K_LAST) begin
                        carry_r     <= add_cout;
                        overflow_r  <= ovf_s;
                        res_valid_r <= 1'b1;
                        k_r         <= {KW{1'b0}};
                        state_r     <= DONE;
                    end else begin
                        k_r         <= k_r + KW'(1'b1);
                    end
                end
                DONE: begin
                    // Ready returns one cycle after the result is taken: no bypass.
                    if (io.res_ready) begin
                        res_valid_r   <= 1'b0;
                        busy_r        <= 1'b0;
                        start_ready_r <= 1'b1;
                        state_r       <= IDLE;
                    end else begin
                        state_r       <= DONE;
                    end
                end
                default: begin
                    res_valid_r   <= 1'b0;
                    busy_r        <= 1'b0;
                    start_ready_r <= 1'b1;
                    state_r       <= IDLE;
                end
            endcase
        end
    end

    assign io.start_ready = start_ready_r;
    assign io.res_valid   = res_valid_r;
    assign io.result      = result_r;
    assign io.carry       = carry_r;
    assign io.overflow    = overflow_r;
    assign busy           = busy_r;
endmodule

// File: doc/rca_nibble_seq.md
Name: rca_nibble_seq

Overview:
- Multi-cycle controller that computes WIDTH-bit add/subtract by time-multiplexing the team's existing 4-bit add/sub ripple-carry slice, one nibble per clock, LSB first.
- The slice stays combinational and external. This block owns operand capture, nibble sequencing, carry chaining, result assembly and the valid/ready handshakes.
- The slice's carry-in is hard-wired to its add/sub select. This block therefore drives the select as the chained carry and pre-conditions the slice's y input so that every nibble computes x + addend + carry.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 8.
- NIB, WIDTH/4, derived nibble count; not overridable.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start_valid  in  1  request present.
- start_ready  out  1  block can accept a request.
- a  in  WIDTH  minuend/augend.
- b  in  WIDTH  subtrahend/addend.
- sub  in  1  1 = a-b, 0 = a+b.
- res_valid  out  1  result held valid.
- res_ready  in  1  consumer accepts result.
- result  out  WIDTH  sum/difference.
- carry  out  1  carry out of the MSB nibble; for subtract, 1 = no borrow.
- overflow  out  1  two's-complement overflow.
- busy  out  1  high in RUN or DONE.
- add_x  out  4  to slice x.
- add_y  out  4  to slice y.
- add_sel  out  1  to slice add/sub select (= slice carry-in).
- add_s  in  4  slice sum.
- add_cout  in  1  slice carry out.

Behaviour:
- Interface (already decided): one clock, clk. Reset rst is asynchronous and active-high.
- Reset values:
  - State IDLE, nibble counter 0, carry register 0.
  - result 0, carry 0, overflow 0, res_valid 0, busy 0.
  - start_ready 1 once rst deasserts.
  - add_x, add_y and add_sel are 0 in IDLE.
- States: IDLE, RUN, DONE.
- IDLE:
  - start_ready=1.
  - On start_valid&start_ready, capture a into A_reg and beff = sub ? ~b : b into B_reg, and latch sub.
  - Set carry register c = sub, counter k=0, then go to RUN.
  - start_ready is 0 in every other state; requests arriving then are ignored.
- RUN, nibble k (combinational drive to slice):
  - add_x = A_reg[4k+3:4k]
  - add_y = B_reg[4k+3:4k] XOR {4{c}}
  - add_sel = c
  - Net slice result: A_nib + B_nib + c.
- RUN, each clock edge:
  - R[4k+3:4k] <= add_s; c <= add_cout; k <= k+1.
  - At k=NIB-1, also latch carry <= add_cout and overflow <= (A_reg[W-1]==B_reg[W-1]) & (add_s[3]!=A_reg[W-1]), then go to DONE.
  - The counter never wraps inside RUN.
- DONE:
  - res_valid=1; result, carry and overflow are stable and held until res_ready.
  - On res_valid&res_ready, go to IDLE and clear res_valid.
  - result, carry and overflow keep their last values; they are meaningful only while res_valid=1.
- Latency: accept at edge 0, res_valid high after edge NIB (4 cycles at WIDTH=16). Throughput is one operation per NIB+2 cycles with res_ready tied high.
- No bypass: the next start cannot be accepted in the same cycle that the result is consumed; it is accepted the cycle after.
- Input operands may change freely after acceptance; only the captured registers are used.
- rst asserted mid-RUN or in DONE aborts immediately: all state returns to reset values, and the partial result is discarded with no res_valid pulse.
- add_* outputs are don't-care-free: they are driven to 0 in IDLE and DONE.

Test Plan:
- WIDTH=16, add 0x1234+0x0FFF -> result 0x2233, carry 0, overflow 0; res_valid 4 cycles after acceptance; add_sel sequence 0,1,1,1.
- Add 0x7FFF+0x0001 -> result 0x8000, carry 0, overflow 1. Add 0xFFFF+0x0001 -> result 0x0000, carry 1, overflow 0.
- Sub 0x0005-0x0007 -> result 0xFFFE, carry 0 (borrow), overflow 0. Sub 0x8000-0x0001 -> result 0x7FFF, carry 1, overflow 1. Sub 0x1234-0x1234 -> result 0x0000, carry 1.
- Backpressure: hold res_ready=0 for 5 cycles after res_valid -> result, carry and overflow stable, start_ready 0, and a start_valid pulse during DONE is ignored. Raising res_ready then gives the handshake; start_ready=1 the next cycle.
- Assert rst for 1 cycle after the 2nd nibble of 0x1234+0x0FFF -> res_valid never rises, outputs 0, start_ready 1 after release; a new op 0x0001+0x0001 then gives 0x0002.
- Back-to-back: 100 random a/b/sub requests with res_ready=1 and start_valid=1, checked against a reference model -> every result, carry and overflow match, one op per 6 cycles.
